// File: rtl/mac_accum.sv
// Saturating dot-product accumulator behind the sequential Booth multiplier.
// Sums LEN signed products, then offers the result on a valid/ready handshake.
module mac_accum #(
  parameter int D_IN  = 8,
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    prod_valid,
  input  logic signed [2*D_IN-1:0] prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    ovf,
  output logic                    lost,
  output logic                    busy,
  output logic [7:0]              prod_cnt
);

  localparam int         P_W     = 2 * D_IN;
  localparam logic [7:0] LEN_CNT = 8'(LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sum_clamp;
  logic [7:0]              cnt_next;

  // One guard bit is enough: the sum is out of range exactly when the two
  // top bits of the widened result disagree, and the guard bit gives the sign.
  // NOTE: every signal written here is assigned first, so no latch is inferred.
  always_comb begin
    sum_wide  = {out_data[ACC_W-1], out_data} + {{(ACC_W + 1 - P_W){prod[P_W-1]}}, prod};
    sum_clamp = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    sum_sat   = sum_wide[ACC_W-1:0];
    if (sum_clamp) begin
      sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
    cnt_next = prod_cnt + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
      prod_cnt  <= 8'd0;
    end else if (start) begin
      // start wins over a coincident product and discards any held result
      state     <= ACCUM;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      out_data  <= '0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
      prod_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (prod_valid) lost <= 1'b1;
        end
        ACCUM: begin
          if (prod_valid) begin
            out_data <= sum_sat;
            prod_cnt <= cnt_next;
            if (sum_clamp) ovf <= 1'b1;
            if (cnt_next == LEN_CNT) begin
              state     <= HOLD;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (prod_valid) lost <= 1'b1;
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three configurations share one stimulus stream and are
// compared every cycle against a per-instance arithmetic model.
module tb_mac_accum;

  logic               clk = 1'b0;
  logic               rst, start, prod_valid, out_ready;
  logic signed [15:0] prod;

  logic               a_valid, a_ovf, a_lost, a_busy;
  logic [7:0]         a_cnt;
  logic signed [23:0] a_data;
  logic               b_valid, b_ovf, b_lost, b_busy;
  logic [7:0]         b_cnt;
  logic signed [15:0] b_data;
  logic               c_valid, c_ovf, c_lost, c_busy;
  logic [7:0]         c_cnt;
  logic signed [15:0] c_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_IDLE = 0, S_ACCUM = 1, S_HOLD = 2;
  int     m_len[3] = '{4, 2, 3};
  int     m_w[3]   = '{24, 16, 16};
  int     m_st[3];
  longint m_acc[3];
  int     m_cnt[3];
  bit     m_ovf[3], m_lost[3];

  always #5 clk = ~clk;

  mac_accum #(.D_IN(8), .ACC_W(24), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod(prod),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .ovf(a_ovf),
    .lost(a_lost), .busy(a_busy), .prod_cnt(a_cnt));

  mac_accum #(.D_IN(8), .ACC_W(16), .LEN(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod(prod),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .ovf(b_ovf),
    .lost(b_lost), .busy(b_busy), .prod_cnt(b_cnt));

  mac_accum #(.D_IN(8), .ACC_W(16), .LEN(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod(prod),
    .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data), .ovf(c_ovf),
    .lost(c_lost), .busy(c_busy), .prod_cnt(c_cnt));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a dot product clamped to the signed range after every addition.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      longint hi = (longint'(1) <<< (m_w[i] - 1)) - 1;
      longint lo = -(longint'(1) <<< (m_w[i] - 1));
      longint s;
      if (rst) begin
        m_st[i] = S_IDLE; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
      end else if (start) begin
        m_st[i] = S_ACCUM; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
      end else if (m_st[i] == S_ACCUM) begin
        if (prod_valid) begin
          s = m_acc[i] + longint'(prod);
          if (s > hi) begin s = hi; m_ovf[i] = 1; end
          if (s < lo) begin s = lo; m_ovf[i] = 1; end
          m_acc[i] = s;
          m_cnt[i]++;
          if (m_cnt[i] == m_len[i]) m_st[i] = S_HOLD;
        end
      end else begin
        if (prod_valid) m_lost[i] = 1;
        if (m_st[i] == S_HOLD && out_ready) m_st[i] = S_IDLE;
      end
    end
  endtask

  task automatic check_inst(input string nm, input int i, input logic v, input logic b,
                            input logic o, input logic l, input logic [7:0] c,
                            input logic signed [63:0] d);
    check({nm, ".out_valid"}, v, m_st[i] == S_HOLD);
    check({nm, ".busy"}, b, m_st[i] == S_ACCUM);
    check({nm, ".ovf"}, o, m_ovf[i]);
    check({nm, ".lost"}, l, m_lost[i]);
    check({nm, ".prod_cnt"}, c, m_cnt[i]);
    check({nm, ".out_data"}, d, m_acc[i]);
  endtask

  // One clock: model follows the sampled inputs, outputs are checked 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_inst("a", 0, a_valid, a_busy, a_ovf, a_lost, a_cnt, a_data);
    check_inst("b", 1, b_valid, b_busy, b_ovf, b_lost, b_cnt, b_data);
    check_inst("c", 2, c_valid, c_busy, c_ovf, c_lost, c_cnt, c_data);
  endtask

  task automatic idle(input int n);
    start = 0; prod_valid = 0; out_ready = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_start();
    start = 1; prod_valid = 0; step(); start = 0;
  endtask

  task automatic push(input logic signed [15:0] p);
    prod_valid = 1; prod = p; step(); prod_valid = 0;
  endtask

  task automatic accept();
    out_ready = 1; step(); out_ready = 0;
  endtask

  initial begin
    rst = 1; start = 0; prod_valid = 0; out_ready = 0; prod = '0;
    step();
    check("reset.a_data", a_data, 0);
    check("reset.a_valid", a_valid, 0);
    rst = 0;
    idle(2);

    // Basic dot product on the 24-bit, LEN=4 instance
    do_start();
    check("start.busy", a_busy, 1);
    push(16'sd1); idle(2);
    push(-16'sd16256); idle(1);
    push(16'sd16384); idle(3);
    push(16'sd16129);
    check("dot.valid", a_valid, 1);
    check("dot.data", a_data, 16258);
    check("dot.ovf", a_ovf, 0);
    check("dot.cnt", a_cnt, 4);
    check("dot.busy", a_busy, 0);

    // Backpressure: result must hold for 10 cycles, then drop after acceptance
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp.data", a_data, 16258);
      check("bp.valid", a_valid, 1);
    end
    accept();
    check("bp.valid_drop", a_valid, 0);
    check("bp.data_after", a_data, 16258);
    idle(1);
    check("bp.ready_idle", a_valid, 0);

    // Saturation positive on 16-bit LEN=2, negative on 16-bit LEN=3
    do_start();
    push(16'sd16384); push(16'sd16384);
    check("sat_pos.data", b_data, 32767);
    check("sat_pos.ovf", b_ovf, 1);
    accept();
    do_start();
    push(-16'sd16384); push(-16'sd16384); push(-16'sd16384);
    check("sat_neg.data", c_data, -32768);
    check("sat_neg.ovf", c_ovf, 1);
    check("sat_neg.valid", c_valid, 1);
    accept();
    idle(1);

    // Abort and start/product collision
    do_start();
    push(16'sd100);
    start = 1; prod_valid = 1; prod = 16'sd50; step(); start = 0; prod_valid = 0;
    check("collide.data", a_data, 0);
    check("collide.lost", a_lost, 0);
    for (int k = 0; k < 4; k++) push(16'sd7);
    check("abort.data", a_data, 28);
    check("abort.lost", a_lost, 0);
    accept();

    // Lost products in IDLE and HOLD
    push(16'sd500);
    check("lost_idle.lost", a_lost, 1);
    check("lost_idle.data", a_data, 28);
    do_start();
    push(16'sd5); push(16'sd6); push(16'sd7); push(16'sd8);
    check("hold.lost_pre", a_lost, 0);
    push(16'sd1000);
    check("lost_hold.lost", a_lost, 1);
    check("lost_hold.data", a_data, 26);
    check("lost_hold.valid", a_valid, 1);
    do_start();
    check("lost_clear", a_lost, 0);

    // Synchronous reset mid-accumulation
    push(16'sd300); push(16'sd400);
    rst = 1; step(); rst = 0;
    check("rst.data", a_data, 0);
    check("rst.cnt", a_cnt, 0);
    check("rst.busy", a_busy, 0);
    check("rst.valid", a_valid, 0);
    do_start();
    push(16'sd1000); push(-16'sd3); push(16'sd250); push(-16'sd7);
    check("rerun.data", a_data, 1240);
    check("rerun.valid", a_valid, 1);
    accept();

    // Randomized traffic, biased toward large magnitudes to hit saturation
    for (int k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 63) == 0);
      start      = ($urandom_range(0, 15) == 0);
      prod_valid = ($urandom_range(0, 1) == 1);
      out_ready  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       prod = 16'($urandom);
        1:       prod = 16'($urandom_range(16384, 32767));
        2:       prod = 16'($urandom_range(32768, 49152));
        default: prod = 16'($urandom_range(0, 15));
      endcase
      step();
    end
    rst = 0; start = 0; prod_valid = 0; out_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
